// File: rtl/toggle_gen_pkg.sv
// toggle_gen_pkg: state encoding and default widths shared by the square-wave generator
package toggle_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int BURST_W_DEF = 8;
endpackage

// File: rtl/toggle_gen_if.sv
// toggle_gen_if: control/status bundle between a controller (master) and the generator (slave)
interface toggle_gen_if #(
  parameter int CNT_W = 16,
  parameter int BURST_W = 8
) ();
  logic start;
  logic stop;
  logic [CNT_W-1:0] half_period;
  logic [BURST_W-1:0] burst_len;
  logic a_out;
  logic busy;
  logic done;
  logic [BURST_W-1:0] periods;
  modport master (output start, stop, half_period, burst_len, input a_out, busy, done, periods);
  modport slave (input start, stop, half_period, burst_len, output a_out, busy, done, periods);
endinterface

// File: rtl/toggle_gen_half_period_ctr.sv
// half_period_ctr: counts 0..h-1 while enabled and flags the last count of each half period
module half_period_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] h,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = enable && cnt == h - 1'b1;
  always_ff @(posedge clk)
    if (clear) cnt <= '0;
    else if (enable) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/toggle_gen.sv
// toggle_gen: clock-counted square-wave source with burst/continuous modes and start/stop control
module toggle_gen
  import toggle_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  toggle_gen_if.slave bus
);
  state_t state, state_d;
  logic [CNT_W-1:0] h_q;
  logic [BURST_W-1:0] n_q, periods, periods_inc;
  logic a_q, tc, run, start_ok, fall, last;
  assign run = state == RUN;
  assign start_ok = state == IDLE && bus.start && !bus.stop;
  assign periods_inc = periods + 1'b1;
  assign fall = tc && a_q;
  assign last = fall && n_q != '0 && periods_inc == n_q;
  half_period_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk   (clk),
    .clear (!rst_n || !run || bus.stop),
    .enable(run),
    .h     (h_q),
    .tc    (tc)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_d;
  // stop outranks completion; DONE and any stray encoding fall back to IDLE
  always_comb begin
    state_d = start_ok ? RUN : run ? (bus.stop ? IDLE : last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      periods <= '0;
      h_q <= '0;
      n_q <= '0;
    end else if (start_ok) begin
      a_q <= 1'b0;
      periods <= '0;
      h_q <= bus.half_period == '0 ? CNT_W'(1) : bus.half_period;
      n_q <= bus.burst_len;
    end else if (run) begin
      a_q <= !bus.stop && (tc ? !a_q : a_q);
      if (!bus.stop && fall) periods <= periods_inc;
    end
  end
  assign bus.a_out = a_q;
  assign bus.busy = run;
  assign bus.done = state == DONE;
  assign bus.periods = periods;
endmodule

// File: tb/tb_toggle_gen.sv
// tb_toggle_gen: directed scenario checks of toggle_gen waveform, status and control corner cases
module tb_toggle_gen;
  import toggle_gen_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  toggle_gen_if #(.CNT_W(CNT_W_DEF), .BURST_W(BURST_W_DEF)) bus ();
  toggle_gen #(.CNT_W(CNT_W_DEF), .BURST_W(BURST_W_DEF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  logic [10:0] obs;
  logic        y;
  assign obs = {bus.a_out, bus.busy, bus.done, bus.periods};
  assign y = ~bus.a_out;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.half_period = '0;
    bus.burst_len = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL reset obs=%h exp=%h", obs, 11'h000);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL reset_release obs=%h exp=%h", obs, 11'h000);
    end
  endtask

  task automatic test_burst_h5;
    logic [10:0] e;
    bus.half_period = 16'd5;
    bus.burst_len = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (obs !== {3'b010, 8'd0}) begin
      failures++;
      $display("FAIL burst_h5_start obs=%h exp=%h", obs, {3'b010, 8'd0});
    end
    for (int k = 1; k <= 34; k++) begin
      tick();
      e = {k < 30 && ((k / 5) % 2) == 1, k < 30, k == 30, 8'(k >= 30 ? 3 : k / 10)};
      checks++;
      if (obs !== e || y !== ~bus.a_out) begin
        failures++;
        $display("FAIL burst_h5 k=%0d obs=%h exp=%h y=%b", k, obs, e, y);
      end
    end
  endtask

  task automatic test_h0;
    logic [10:0] e;
    bus.half_period = 16'd0;
    bus.burst_len = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = {k < 4 && (k % 2) == 1, k < 4, k == 4, 8'(k >= 4 ? 2 : k / 2)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL h0 k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_continuous;
    logic [10:0] e;
    bus.half_period = 16'd1;
    bus.burst_len = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      e = {(k % 2) == 1, 1'b1, 1'b0, 8'((k / 2) % 256)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL continuous k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== {3'b000, 8'd44}) begin
        failures++;
        $display("FAIL continuous_stop k=%0d obs=%h exp=%h", k, obs, {3'b000, 8'd44});
      end
      tick();
    end
  endtask

  task automatic test_restart_ignored;
    logic [10:0] e;
    bus.half_period = 16'd4;
    bus.burst_len = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k == 6) begin
        bus.start = 1'b1;
        bus.half_period = 16'd9;
        bus.burst_len = 8'd7;
      end else bus.start = 1'b0;
      tick();
      e = {k < 16 && ((k / 4) % 2) == 1, k < 16, k == 16, 8'(k >= 16 ? 2 : k / 8)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL restart_ignored k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [10:0] e;
    bus.half_period = 16'd5;
    bus.burst_len = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) rst_n = 1'b0;
      tick();
      e = k == 7 ? 11'h000 : {(k / 5) % 2 == 1, 1'b1, 1'b0, 8'd0};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL reset_mid_idle obs=%h exp=%h", obs, 11'h000);
    end
    bus.half_period = 16'd2;
    bus.burst_len = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = {k == 2 || k == 3, k < 4, k == 4, 8'(k >= 4 ? 1 : 0)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_restart k=%0d obs=%h exp=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_start_stop;
    bus.half_period = 16'd3;
    bus.burst_len = 8'd2;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== {3'b000, 8'd1}) begin
        failures++;
        $display("FAIL start_stop k=%0d obs=%h exp=%h", k, obs, {3'b000, 8'd1});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_burst_h5();
    test_h0();
    test_continuous();
    test_restart_ignored();
    test_reset_mid();
    test_start_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
